sequenced_decoder: RTL
======================

SEQUENCED_DECODER -- requirements
Module: sequenced_decoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, address width in bits; legal range 1..6.
REQ-002 SHALL have parameter STOP_AT_WRAP, default 0; 0 = scan wraps forever, 1 = scan stops after the last output.
REQ-003 SHALL have localparam OUT_W = 2**ADDR_W, the number of one-hot outputs.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: output gate; 0 forces out to zero.
REQ-007 SHALL have port clear, input, 1 bit: synchronous return to IDLE.
REQ-008 SHALL have port load, input, 1 bit: captures address and mode.
REQ-009 SHALL have port mode, input, 1 bit: 0 = HOLD (direct decode), 1 = SCAN.
REQ-010 SHALL have port step, input, 1 bit: advances the scan position by one.
REQ-011 SHALL have port address, input, ADDR_W bits: start or direct address.
REQ-012 SHALL have port out, output, OUT_W bits: registered one-hot decode.
REQ-013 SHALL have port cur_addr, output, ADDR_W bits: registered current position.
REQ-014 SHALL have port active, output, 1 bit: 1 when the state is not IDLE.
REQ-015 SHALL have port wrap, output, 1 bit: single-cycle pulse on a scan wrap or stop.

Function
REQ-016 SHALL implement three states: IDLE, HOLD and SCAN.
REQ-017 SHALL register all outputs; every output change SHALL occur on a clk rising edge.
REQ-018 SHALL drive out to onehot(cur_addr) when the state is not IDLE and enable was 1 at the same edge; otherwise out SHALL be all zero.
REQ-019 SHALL set out bit k to 1 exactly when cur_addr equals k; no other bit SHALL be 1.
REQ-020 SHALL, on load in any state, set cur_addr to address and move to HOLD if mode=0 or SCAN if mode=1; out SHALL reflect the new address one cycle after load.
REQ-021 SHALL, on step in SCAN without load, set cur_addr to (cur_addr+1) mod OUT_W.
REQ-022 SHALL, on step in SCAN at cur_addr=OUT_W-1 with STOP_AT_WRAP=0, set cur_addr to 0, stay in SCAN and pulse wrap for one cycle.
REQ-023 SHALL, on step in SCAN at cur_addr=OUT_W-1 with STOP_AT_WRAP=1, move to IDLE, hold cur_addr, clear out and pulse wrap for one cycle.
REQ-024 SHALL ignore step in HOLD and in IDLE.
REQ-025 SHALL apply priority clear > load > step when these inputs are asserted in the same cycle.
REQ-026 SHALL, on clear, move to IDLE and set out to 0, active to 0, wrap to 0 and cur_addr to 0.
REQ-027 SHALL keep the state and cur_addr unchanged when enable=0; only out is gated by enable.
REQ-028 SHALL drive wrap to 0 in every cycle other than those given in REQ-022 and REQ-023.

Reset
REQ-029 SHALL, on rst_n=0 and independent of clk, force IDLE with cur_addr=0, out=0, active=0 and wrap=0.
REQ-030 SHALL, when reset is asserted mid-scan, abandon the scan immediately; after release the block SHALL stay in IDLE until the next load.

Structure
REQ-031 SHALL take the state encoding type and the MODE_HOLD and MODE_SCAN constants from the shared package sequenced_decoder_pkg.
REQ-032 SHALL instantiate one combinational sub-module onehot_decode, parametrised by ADDR_W, that maps an address to an OUT_W-bit one-hot vector with an enable input.

Verification
REQ-033 SHALL cover direct decode: ADDR_W=3, load=1, mode=0, address=5, enable=1 -> out=8'b0010_0000 and active=1 on the next cycle; step has no effect.
REQ-034 SHALL cover scan wrap: STOP_AT_WRAP=0, load address=6 in SCAN, then 3 steps -> cur_addr 7, 0, 1; wrap=1 only in the cycle cur_addr becomes 0.
REQ-035 SHALL cover scan stop: STOP_AT_WRAP=1, load address=7 in SCAN, then 1 step -> state IDLE, out=0, active=0, wrap pulses once, cur_addr=7.
REQ-036 SHALL cover simultaneous inputs in SCAN: clear+load+step together -> IDLE and cur_addr=0; load+step together with address=2 -> cur_addr=2, not 3.
REQ-037 SHALL cover enable gating: HOLD at address=3, enable=0 for 2 cycles -> out=0 while cur_addr=3 and active=1; enable=1 -> out=8'b0000_1000.
REQ-038 SHALL cover reset mid-scan: rst_n low between clock edges during SCAN -> all outputs zero immediately; after release, out stays 0 until load.

Source files
------------

// File: rtl/sequenced_decoder_pkg.sv
// Shared types and constants for the sequenced decoder.
//   state_t   : controller state encoding (IDLE / HOLD / SCAN)
//   MODE_HOLD : mode input value selecting direct decode
//   MODE_SCAN : mode input value selecting stepped scan
package sequenced_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  localparam logic MODE_HOLD = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

endpackage

// File: rtl/sequenced_decoder_onehot_decode.sv
// Combinational address-to-one-hot decoder.
//   addr : ADDR_W-bit address
//   en   : 0 forces the whole vector to zero
//   oh   : 2**ADDR_W-bit one-hot result, bit k set when addr == k
module onehot_decode #(
  parameter int ADDR_W = 3,
  localparam int OUT_W = 2**ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [OUT_W-1:0]  oh
);

  for (genvar k = 0; k < OUT_W; k++) begin : g_bit
    assign oh[k] = en && (addr == ADDR_W'(k));
  end

endmodule

// File: rtl/sequenced_decoder.sv
// Sequenced one-hot decoder: holds a directly loaded address or scans
// upward from a loaded start address, one position per step.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   enable     : gates out only; state and position keep running
//   clear      : synchronous return to IDLE (highest priority)
//   load       : capture address and mode (beats step)
//   mode       : MODE_HOLD direct decode, MODE_SCAN stepped scan
//   step       : advance scan position (SCAN only)
//   address    : start / direct address
//   out        : registered one-hot of cur_addr, zero in IDLE or when gated
//   cur_addr   : registered current position
//   active     : registered, 1 when not IDLE
//   wrap       : one-cycle pulse when the scan passes the last position
module sequenced_decoder
  import sequenced_decoder_pkg::*;
#(
  parameter int ADDR_W       = 3,
  parameter bit STOP_AT_WRAP = 1'b0,
  localparam int OUT_W       = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              load,
  input  logic              mode,
  input  logic              step,
  input  logic [ADDR_W-1:0] address,
  output logic [OUT_W-1:0]  out,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              active,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(OUT_W-1);

  state_t             state, nxt_state;
  logic [ADDR_W-1:0]  nxt_addr;
  logic               nxt_wrap;
  logic [OUT_W-1:0]   nxt_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cur_addr <= '0;
      out      <= '0;
      active   <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state    <= nxt_state;
      cur_addr <= nxt_addr;
      out      <= nxt_out;
      active   <= (nxt_state != ST_IDLE);
      wrap     <= nxt_wrap;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_addr  = cur_addr;
    nxt_wrap  = 1'b0;
    if (clear) begin
      nxt_state = ST_IDLE;
      nxt_addr  = '0;
    end else if (load) begin
      nxt_addr  = address;
      nxt_state = (mode == MODE_SCAN) ? ST_SCAN : ST_HOLD;
    end else if (step && state == ST_SCAN) begin
      if (cur_addr == LAST) begin
        nxt_wrap = 1'b1;
        // Stop mode parks on the last position so software can see where it ended.
        if (STOP_AT_WRAP) nxt_state = ST_IDLE;
        else              nxt_addr  = '0;
      end else begin
        nxt_addr = cur_addr + 1'b1;
      end
    end
  end

  // Decode the next position so out lines up with cur_addr on the same edge.
  onehot_decode #(.ADDR_W(ADDR_W)) u_dec (
    .addr (nxt_addr),
    .en   (enable && (nxt_state != ST_IDLE)),
    .oh   (nxt_out)
  );

endmodule
